// File: rtl/self_draw_pkg.sv
`default_nettype none
//==============================================================================
// Module      : self_pkg
// Description : Shared encodings for the player-ship pixel engine: phase codes
//               advertised to the ship controller, op codes, colours, screen
//               limits and the engine's FSM state type.
// Revision    : 1.0 - initial release
//==============================================================================
package self_pkg;

    // Phase codes seen by the ship controller on self_state
    localparam logic [3:0] SELF_ST_DRAW  = 4'd1;
    localparam logic [3:0] SELF_ST_ERASE = 4'd2;
    localparam logic [3:0] SELF_ST_HOLD  = 4'd3;

    // Controller commands (2'b11 is reserved and behaves like OP_DRAW)
    localparam logic [1:0] OP_DRAW  = 2'b00;
    localparam logic [1:0] OP_ERASE = 2'b01;
    localparam logic [1:0] OP_FIRE  = 2'b10;

    // Framebuffer colours
    localparam logic [2:0] COL_SHIP  = 3'b111;
    localparam logic [2:0] COL_FIRE  = 3'b100;
    localparam logic [2:0] COL_BLACK = 3'b000;

    // Visible screen size
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    // Engine sequencing states
    typedef enum logic [2:0] {
        ST_LOAD_D = 3'd0,
        ST_DRAW   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_LOAD_E = 3'd3,
        ST_ERASE  = 3'd4
    } self_fsm_t;

    // Map an engine state onto the phase code the controller understands
    function automatic logic [3:0] phase_code(input self_fsm_t s);
        case (s)
            ST_HOLD:            phase_code = SELF_ST_HOLD;
            ST_LOAD_E, ST_ERASE: phase_code = SELF_ST_ERASE;
            default:            phase_code = SELF_ST_DRAW;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/self_draw_if.sv
`default_nettype none
//==============================================================================
// Module      : self_draw_if
// Description : Command handshake between the ship controller (master) and
//               the ship pixel engine (slave).
// Revision    : 1.0 - initial release
//==============================================================================
interface self_draw_if;

    logic       self_enable;
    logic [1:0] op;
    logic [7:0] x;
    logic [3:0] self_state;

    modport master (output self_enable, output op, output x, input  self_state);
    modport slave  (input  self_enable, input  op, input  x, output self_state);

endinterface
`default_nettype wire

// File: rtl/self_pixel_scan.sv
`default_nettype none
//==============================================================================
// Module      : self_pixel_scan
// Description : Walks the sprite pixel set: optional shot column (top to
//               bottom) followed by the ship body in row-major order. The
//               outputs describe the pixel to be presented on the next cycle;
//               the internal pointer follows whenever start or step is high.
// Revision    : 1.0 - initial release
//==============================================================================
module self_pixel_scan #(
    parameter int SHIP_W   = 8,
    parameter int SHIP_H   = 4,
    parameter int FIRE_LEN = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       step,
    input  logic       fire,
    output logic [7:0] col,
    output logic [6:0] row,
    output logic       in_fire,
    output logic       last
);

    localparam logic [7:0] c_COL_LAST  = 8'(SHIP_W - 1);
    localparam logic [6:0] c_ROW_LAST  = 7'(SHIP_H - 1);
    localparam logic [6:0] c_FIRE_LAST = 7'(FIRE_LEN - 1);

    logic       r_in_fire;
    logic [7:0] r_col;
    logic [6:0] r_row;

    logic       w_in_fire;
    logic [7:0] w_col;
    logic [6:0] w_row;

    // Successor of the current pointer, or the first pixel on start
    always_comb begin
        w_in_fire = r_in_fire;
        w_col     = r_col;
        w_row     = r_row;
        if (start) begin
            w_in_fire = fire;
            w_col     = '0;
            w_row     = '0;
        end else if (r_in_fire) begin
            if (r_row == c_FIRE_LAST) begin
                w_in_fire = 1'b0;
                w_row     = '0;
            end else begin
                w_row = r_row + 7'd1;
            end
        end else if (r_col == c_COL_LAST) begin
            w_col = '0;
            w_row = r_row + 7'd1;
        end else begin
            w_col = r_col + 8'd1;
        end
    end

    // Pointer register tracks the pixel currently being presented
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_fire <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
        end else if (start || step) begin
            r_in_fire <= w_in_fire;
            r_col     <= w_col;
            r_row     <= w_row;
        end
    end

    assign col     = w_col;
    assign row     = w_row;
    assign in_fire = w_in_fire;
    assign last    = !w_in_fire && (w_col == c_COL_LAST) && (w_row == c_ROW_LAST);

endmodule
`default_nettype wire

// File: rtl/self_draw.sv
`default_nettype none
//==============================================================================
// Module      : self_draw
// Description : Player-ship pixel engine. Sequences draw -> hold -> erase,
//               advertises the phase to the ship controller and emits one
//               registered framebuffer write per cycle for the sprite and,
//               when firing, the shot column.
// Revision    : 1.0 - initial release
//==============================================================================
module self_draw
    import self_pkg::*;
#(
    parameter int SHIP_W     = 8,
    parameter int SHIP_H     = 4,
    parameter int SHIP_Y     = 110,
    parameter int FIRE_LEN   = 16,
    parameter int FRAME_WAIT = 833333
) (
    input  logic        clk,
    input  logic        reset_n,
    self_draw_if.slave  ctrl,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        frame_done
);

    localparam int                    c_HOLD_W    = (FRAME_WAIT > 1) ? $clog2(FRAME_WAIT) : 1;
    localparam logic [c_HOLD_W-1:0]   c_HOLD_LAST = c_HOLD_W'(FRAME_WAIT - 1);
    localparam logic [8:0]            c_X_MAX     = 9'(SCR_W - 1);
    localparam logic [8:0]            c_FIRE_OFF  = 9'(SHIP_W / 2);
    localparam logic [6:0]            c_FIRE_Y0   = 7'(SHIP_Y - FIRE_LEN);
    localparam logic [6:0]            c_SHIP_Y0   = 7'(SHIP_Y);

    self_fsm_t             r_state;
    self_fsm_t             w_next;
    logic [7:0]            r_x_l;
    logic                  r_fire_l;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic                  r_last;
    logic [7:0]            r_vga_x;
    logic [6:0]            r_vga_y;
    logic [2:0]            r_colour;
    logic                  r_plot;
    logic                  r_frame_done;

    logic                  w_start_d;
    logic                  w_start_e;
    logic                  w_start;
    logic                  w_step;
    logic                  w_emit;
    logic                  w_erasing;
    logic                  w_fire_sel;
    logic                  w_hold_done;
    logic [7:0]            w_x_src;
    logic [7:0]            w_col;
    logic [6:0]            w_row;
    logic                  w_in_fire;
    logic                  w_scan_last;
    logic [8:0]            w_sum;
    logic [6:0]            w_y;
    logic [2:0]            w_colour;

    // The controller only gets its command consumed in the matching LOAD state
    assign w_start_d   = (r_state == ST_LOAD_D) && ctrl.self_enable && (ctrl.op != OP_ERASE);
    assign w_start_e   = (r_state == ST_LOAD_E) && ctrl.self_enable && (ctrl.op == OP_ERASE);
    assign w_start     = w_start_d || w_start_e;
    assign w_step      = ((r_state == ST_DRAW) || (r_state == ST_ERASE)) && !r_last;
    assign w_emit      = w_start || w_step;
    assign w_erasing   = (r_state == ST_LOAD_E) || (r_state == ST_ERASE);
    assign w_hold_done = (r_hold_cnt == c_HOLD_LAST);

    // x/fire are not latched yet on the LOAD_D cycle, so pixel 0 uses them live
    assign w_fire_sel  = (r_state == ST_LOAD_D) ? (ctrl.op == OP_FIRE) : r_fire_l;
    assign w_x_src     = (r_state == ST_LOAD_D) ? ctrl.x : r_x_l;

    self_pixel_scan #(
        .SHIP_W   (SHIP_W),
        .SHIP_H   (SHIP_H),
        .FIRE_LEN (FIRE_LEN)
    ) u_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_start),
        .step    (w_step),
        .fire    (w_fire_sel),
        .col     (w_col),
        .row     (w_row),
        .in_fire (w_in_fire),
        .last    (w_scan_last)
    );

    // Nine-bit column sum so that off-screen pixels can be detected and clipped
    assign w_sum    = {1'b0, w_x_src} + (w_in_fire ? c_FIRE_OFF : {1'b0, w_col});
    assign w_y      = (w_in_fire ? c_FIRE_Y0 : c_SHIP_Y0) + w_row;
    assign w_colour = w_erasing ? COL_BLACK : (w_in_fire ? COL_FIRE : COL_SHIP);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_LOAD_D;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD_D: if (w_start_d)   w_next = ST_DRAW;
            ST_DRAW:   if (r_last)      w_next = ST_HOLD;
            ST_HOLD:   if (w_hold_done) w_next = ST_LOAD_E;
            ST_LOAD_E: if (w_start_e)   w_next = ST_ERASE;
            ST_ERASE:  if (r_last)      w_next = ST_LOAD_D;
            default:                    w_next = ST_LOAD_D;
        endcase
    end

    // Latch position and fire flag once per frame; erase reuses them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x_l    <= '0;
            r_fire_l <= 1'b0;
        end else if (w_start_d) begin
            r_x_l    <= ctrl.x;
            r_fire_l <= (ctrl.op == OP_FIRE);
        end
    end

    // Hold timer runs only while in HOLD and restarts on every entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                r_hold_cnt <= '0;
        else if (r_state != ST_HOLD) r_hold_cnt <= '0;
        else if (w_hold_done)        r_hold_cnt <= '0;
        else                         r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
    end

    // Registered pixel outputs; frame_done rides along with the last erase pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
            r_plot       <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_colour     <= '0;
        end else begin
            r_last       <= w_emit && w_scan_last;
            r_frame_done <= w_emit && w_erasing && w_scan_last;
            r_plot       <= w_emit && (w_sum <= c_X_MAX);
            if (w_emit) begin
                r_vga_x  <= w_sum[7:0];
                r_vga_y  <= w_y;
                r_colour <= w_colour;
            end
        end
    end

    assign ctrl.self_state = phase_code(r_state);
    assign vga_x           = r_vga_x;
    assign vga_y           = r_vga_y;
    assign colour          = r_colour;
    assign plot            = r_plot;
    assign frame_done      = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_self_draw.sv
`default_nettype none
//==============================================================================
// Module      : tb_self_draw
// Description : Self-checking bench for self_draw. A frame-level model builds
//               the expected per-cycle pixel stream from the sprite geometry
//               and compares it with what the engine presents.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_self_draw;

    localparam int SHIP_W     = 8;
    localparam int SHIP_H     = 4;
    localparam int SHIP_Y     = 110;
    localparam int FIRE_LEN   = 16;
    localparam int FRAME_WAIT = 20;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       frame_done;

    int n_cmp;
    int n_bad;

    self_draw_if ctrl();

    self_draw #(
        .SHIP_W     (SHIP_W),
        .SHIP_H     (SHIP_H),
        .SHIP_Y     (SHIP_Y),
        .FIRE_LEN   (FIRE_LEN),
        .FRAME_WAIT (FRAME_WAIT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl       (ctrl),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .colour     (colour),
        .plot       (plot),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // expected and observed per-cycle streams
    logic       exp_p[$], exp_fd[$], exp_chk[$];
    logic [7:0] exp_x[$];
    logic [6:0] exp_y[$];
    logic [2:0] exp_c[$];
    logic [3:0] exp_st[$];
    logic       obs_p[$], obs_fd[$];
    logic [7:0] obs_x[$];
    logic [6:0] obs_y[$];
    logic [2:0] obs_c[$];
    logic [3:0] obs_st[$];

    function automatic void push_exp(logic p, logic [7:0] xx, logic [6:0] yy,
                                     logic [2:0] cc, logic [3:0] st, logic fd, logic chk);
        exp_p.push_back(p);   exp_x.push_back(xx);  exp_y.push_back(yy);
        exp_c.push_back(cc);  exp_st.push_back(st); exp_fd.push_back(fd);
        exp_chk.push_back(chk);
    endfunction

    // Frame model: draw pixels, hold, one LOAD_E cycle, erase pixels
    function automatic void build_frame(int xl, bit fire);
        int n;
        int k;
        int xs;
        exp_p.delete(); exp_x.delete(); exp_y.delete(); exp_c.delete();
        exp_st.delete(); exp_fd.delete(); exp_chk.delete();
        n = SHIP_W * SHIP_H + (fire ? FIRE_LEN : 0);
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) push_exp(1'b0, 8'd0, 7'd0, 3'd0, 4'd2, 1'b0, 1'b0);
            k = 0;
            if (fire) begin
                for (int r = 0; r < FIRE_LEN; r++) begin
                    xs = xl + SHIP_W / 2;
                    push_exp(xs < 160, 8'(xs % 256), 7'(SHIP_Y - FIRE_LEN + r),
                             (ph == 1) ? 3'b000 : 3'b100, (ph == 1) ? 4'd2 : 4'd1,
                             (ph == 1) && (k == n - 1), 1'b1);
                    k++;
                end
            end
            for (int r = 0; r < SHIP_H; r++) begin
                for (int c = 0; c < SHIP_W; c++) begin
                    xs = xl + c;
                    push_exp(xs < 160, 8'(xs % 256), 7'(SHIP_Y + r),
                             (ph == 1) ? 3'b000 : 3'b111, (ph == 1) ? 4'd2 : 4'd1,
                             (ph == 1) && (k == n - 1), 1'b1);
                    k++;
                end
            end
            if (ph == 0) repeat (FRAME_WAIT) push_exp(1'b0, 8'd0, 7'd0, 3'd0, 4'd3, 1'b0, 1'b0);
        end
    endfunction

    task automatic record();
        obs_p.push_back(plot);   obs_x.push_back(vga_x);  obs_y.push_back(vga_y);
        obs_c.push_back(colour); obs_st.push_back(ctrl.self_state);
        obs_fd.push_back(frame_done);
    endtask

    // Play the controller for one whole frame; x moves during HOLD
    task automatic run_frame(logic [7:0] xv, logic [1:0] opv, logic [7:0] xhold);
        int nd;
        ctrl.self_enable = 1'b0;
        @(negedge clk);
        ctrl.self_enable = 1'b1;
        ctrl.op = opv;
        ctrl.x  = xv;
        obs_p.delete(); obs_x.delete(); obs_y.delete(); obs_c.delete();
        obs_st.delete(); obs_fd.delete();
        nd = SHIP_W * SHIP_H + ((opv == 2'b10) ? FIRE_LEN : 0);
        for (int i = 0; i < 2 * nd + FRAME_WAIT + 1; i++) begin
            @(negedge clk);
            record();
            if (i == nd) ctrl.x = xhold;
            if (i == nd + FRAME_WAIT - 1) ctrl.op = 2'b01;
        end
        ctrl.self_enable = 1'b0;
        ctrl.op = 2'b00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ctrl.self_enable = 1'b0;
        ctrl.op = 2'b00;
        ctrl.x  = 8'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ctrl.self_state !== 4'd1) begin n_bad++; $display("FAIL reset_state got %0d want 1", ctrl.self_state); end
        n_cmp++; if (plot !== 1'b0)       begin n_bad++; $display("FAIL reset_plot got %b want 0", plot); end
        n_cmp++; if (vga_x !== 8'd0)      begin n_bad++; $display("FAIL reset_vga_x got %0d want 0", vga_x); end
        n_cmp++; if (vga_y !== 7'd0)      begin n_bad++; $display("FAIL reset_vga_y got %0d want 0", vga_y); end
        n_cmp++; if (colour !== 3'd0)     begin n_bad++; $display("FAIL reset_colour got %0d want 0", colour); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (ctrl.self_state !== 4'd1 || plot !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset state %0d plot %b want 1/0", ctrl.self_state, plot);
        end
    endtask

    // Directed frames from the geometry corner cases, then random frames
    task automatic test_frames();
        logic [7:0] tx[5] = '{8'd82, 8'd40, 8'd156, 8'd200, 8'd156};
        logic [1:0] to[5] = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b10};
        logic [7:0] th[5] = '{8'd92, 8'd40, 8'd0,   8'd5,   8'd3};
        logic [7:0] xv;
        logic [7:0] xh;
        logic [1:0] opv;
        int         pick;
        for (int f = 0; f < 17; f++) begin
            if (f < 5) begin
                xv = tx[f]; opv = to[f]; xh = th[f];
            end else begin
                xv = 8'($urandom_range(0, 255));
                xh = 8'($urandom_range(0, 255));
                pick = $urandom_range(0, 2);
                opv = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b10 : 2'b11;
            end
            run_frame(xv, opv, xh);
            build_frame(int'(xv), opv == 2'b10);
            n_cmp++;
            if (obs_p.size() != exp_p.size()) begin
                n_bad++; $display("FAIL frame%0d length got %0d want %0d", f, obs_p.size(), exp_p.size());
            end
            for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
                n_cmp++; if (obs_st[i] !== exp_st[i]) begin n_bad++; $display("FAIL frame%0d cyc%0d self_state got %0d want %0d", f, i, obs_st[i], exp_st[i]); end
                n_cmp++; if (obs_p[i] !== exp_p[i])   begin n_bad++; $display("FAIL frame%0d cyc%0d plot got %b want %b", f, i, obs_p[i], exp_p[i]); end
                n_cmp++; if (obs_fd[i] !== exp_fd[i]) begin n_bad++; $display("FAIL frame%0d cyc%0d frame_done got %b want %b", f, i, obs_fd[i], exp_fd[i]); end
                if (exp_chk[i]) begin
                    n_cmp++; if (obs_x[i] !== exp_x[i]) begin n_bad++; $display("FAIL frame%0d cyc%0d vga_x got %0d want %0d", f, i, obs_x[i], exp_x[i]); end
                    n_cmp++; if (obs_y[i] !== exp_y[i]) begin n_bad++; $display("FAIL frame%0d cyc%0d vga_y got %0d want %0d", f, i, obs_y[i], exp_y[i]); end
                    n_cmp++; if (obs_c[i] !== exp_c[i]) begin n_bad++; $display("FAIL frame%0d cyc%0d colour got %0d want %0d", f, i, obs_c[i], exp_c[i]); end
                end
            end
        end
    endtask

    // LOAD states must wait on missing enable or on the wrong op
    task automatic test_load_wait();
        logic [7:0] xv;
        int         want_plots;
        int         plots;
        int         fds;
        int         bad_col;
        xv = 8'($urandom_range(100, 159));
        ctrl.self_enable = 1'b0;
        @(negedge clk);
        ctrl.self_enable = 1'b1;
        ctrl.op = 2'b00;
        ctrl.x  = xv;
        repeat (SHIP_W * SHIP_H + FRAME_WAIT + 1) @(negedge clk);
        ctrl.self_enable = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 50) begin ctrl.self_enable = 1'b1; ctrl.op = 2'b00; end
            if (i == 55) ctrl.op = 2'b10;
            if (i == 58) ctrl.op = 2'b11;
            n_cmp++;
            if (ctrl.self_state !== 4'd2 || plot !== 1'b0) begin
                n_bad++; $display("FAIL load_e_wait cyc%0d state %0d plot %b want 2/0", i, ctrl.self_state, plot);
            end
            @(negedge clk);
        end
        ctrl.op = 2'b01;
        want_plots = 0;
        for (int r = 0; r < SHIP_H; r++)
            for (int c = 0; c < SHIP_W; c++)
                if (int'(xv) + c < 160) want_plots++;
        plots = 0; fds = 0; bad_col = 0;
        for (int i = 0; i < SHIP_W * SHIP_H; i++) begin
            @(negedge clk);
            if (plot === 1'b1) plots++;
            if (plot === 1'b1 && colour !== 3'b000) bad_col++;
            if (frame_done === 1'b1) fds++;
            if (i == SHIP_W * SHIP_H - 1) begin
                n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL erase_last_frame_done got %b want 1", frame_done); end
            end
        end
        n_cmp++; if (plots != want_plots) begin n_bad++; $display("FAIL erase_plot_count got %0d want %0d", plots, want_plots); end
        n_cmp++; if (fds != 1)            begin n_bad++; $display("FAIL erase_frame_done_count got %0d want 1", fds); end
        n_cmp++; if (bad_col != 0)        begin n_bad++; $display("FAIL erase_colour nonblack pixels %0d want 0", bad_col); end
        // op stays 01 with enable high: LOAD_D must ignore it
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl.self_state !== 4'd1 || plot !== 1'b0) begin
                n_bad++; $display("FAIL load_d_wrong_op cyc%0d state %0d plot %b want 1/0", i, ctrl.self_state, plot);
            end
        end
        ctrl.self_enable = 1'b0;
        ctrl.op = 2'b00;
    endtask

    // Reset in the middle of a draw aborts at once; next frame starts cleanly
    task automatic test_reset_mid_scan();
        logic [7:0] xn;
        ctrl.self_enable = 1'b0;
        @(negedge clk);
        ctrl.self_enable = 1'b1;
        ctrl.op = 2'b00;
        ctrl.x  = 8'd30;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        n_cmp++; if (plot !== 1'b1 || vga_x !== 8'd32 || vga_y !== 7'd111) begin
            n_bad++; $display("FAIL pixel10 plot %b x %0d y %0d want 1/32/111", plot, vga_x, vga_y);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (plot !== 1'b0)           begin n_bad++; $display("FAIL async_reset_plot got %b want 0", plot); end
        n_cmp++; if (ctrl.self_state !== 4'd1) begin n_bad++; $display("FAIL async_reset_state got %0d want 1", ctrl.self_state); end
        @(negedge clk);
        reset_n = 1'b1;
        xn = 8'($urandom_range(0, 150));
        ctrl.x = xn;
        build_frame(int'(xn), 1'b0);
        for (int k = 0; k < SHIP_W * SHIP_H; k++) begin
            @(negedge clk);
            ctrl.self_enable = 1'b0;
            n_cmp++;
            if (plot !== exp_p[k] || vga_x !== exp_x[k] || vga_y !== exp_y[k] ||
                colour !== exp_c[k] || ctrl.self_state !== exp_st[k]) begin
                n_bad++;
                $display("FAIL restart pix%0d got p%b x%0d y%0d c%0d s%0d want p%b x%0d y%0d c%0d s%0d",
                         k, plot, vga_x, vga_y, colour, ctrl.self_state,
                         exp_p[k], exp_x[k], exp_y[k], exp_c[k], exp_st[k]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_frames();
        test_load_wait();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/self_draw.md
# self_draw

Pixel engine for the player ship, the downstream end of the ship controller's `op`/`x`/`self_enable` interface. It sequences draw → hold → erase phases and advertises the current phase on `self_state`. It accepts the controller's command for that phase and emits one VGA framebuffer write per cycle for the ship sprite and, when firing, the shot column. It sits between the ship controller and the VGA adapter's plot port.

## Interface
- `SHIP_W`, 8: sprite width, pixels.
- `SHIP_H`, 4: sprite height, pixels.
- `SHIP_Y`, 110: top row of sprite.
- `FIRE_LEN`, 16: shot column length, pixels, directly above the sprite.
- `FRAME_WAIT`, 833333: hold cycles between draw and erase (sim: 20).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `self_enable` in 1: controller command valid.
- `op` in 2: 00 draw, 01 erase, 10 draw+fire, 11 reserved (treated as 00).
- `x` in 8: sprite left column.
- `self_state` out 4: phase advertised to controller.
  - 1 = draw phase.
  - 2 = erase phase.
  - 3 = hold.
- `vga_x` out 8: pixel column.
- `vga_y` out 7: pixel row.
- `colour` out 3: pixel colour.
- `plot` out 1: framebuffer write strobe.
- `frame_done` out 1: one-cycle pulse at erase completion.

## Operation
FSM states and `self_state` values:
- **LOAD_D** (1): wait for `self_enable`=1 with `op`≠01.
  - Latch `x_l`=`x`; latch `fire_l`=(`op`==10).
  - → DRAW.
- **DRAW** (1): one pixel per cycle.
  - Scan order: fire column first when `fire_l`, then ship rows.
  - Last pixel → HOLD.
- **HOLD** (3): count `FRAME_WAIT` cycles, then → LOAD_E.
- **LOAD_E** (2): wait for `self_enable`=1 with `op`==01 → ERASE.
  - `x` and `op` are not relatched.
- **ERASE** (2): same scan as DRAW using `x_l`/`fire_l`, `colour`=000.
  - Last pixel → LOAD_D; `frame_done`=1 that cycle.

Pixel sets:
- Fire column: `vga_x`=`x_l`+`SHIP_W`/2, rows `SHIP_Y`-`FIRE_LEN` … `SHIP_Y`-1, top to bottom, `colour`=100.
- Ship: rows `SHIP_Y` … `SHIP_Y`+`SHIP_H`-1, columns `x_l` … `x_l`+`SHIP_W`-1, row-major, `colour`=111.

Rules:
- Column sum is computed 9 bits wide. When the sum > 159, `plot`=0 for that pixel, but the cycle is still consumed and `vga_x` carries the low 8 bits.
- `op` changes outside LOAD_D/LOAD_E are ignored.
- `self_enable`=0 in a LOAD state: wait indefinitely.
- Wrong `op` in a LOAD state (01 in LOAD_D, non-01 in LOAD_E): ignored, keep waiting.

## Timing
- Reset values:
  - State LOAD_D.
  - `self_state`=1.
  - `plot`, `vga_x`, `vga_y`, `colour`, `frame_done`, `x_l`, `fire_l` all 0.
- `self_state` is combinational from state; the controller's `op` is combinational from `self_state`, so LOAD_D/LOAD_E take exactly 1 cycle when the controller is ready.
- Pixel outputs are registered. Pixel k of a scan is presented on the k-th cycle after the LOAD→DRAW/ERASE edge (k=0 first).
- `plot` is high only in DRAW/ERASE cycles (minus clipped pixels).
- DRAW/ERASE length:
  - `SHIP_W`×`SHIP_H` = 32 cycles.
  - `SHIP_W`×`SHIP_H` + `FIRE_LEN` = 48 cycles with `fire_l`.
- HOLD lasts exactly `FRAME_WAIT` cycles.
- Full frame (controller ready): 1+32+`FRAME_WAIT`+1+32 cycles; 32 → 48 when firing.
- Reset mid-scan:
  - Immediate abort; `plot` drops asynchronously.
  - The partially drawn sprite remains in the framebuffer; the top level clears the screen on reset.

## Structure
- Shared package `self_pkg`:
  - `self_state` encodings (SELF_ST_DRAW=1, SELF_ST_ERASE=2, SELF_ST_HOLD=3).
  - `op` encodings (OP_DRAW, OP_ERASE, OP_FIRE).
  - Colour constants (COL_SHIP, COL_FIRE, COL_BLACK).
  - Screen limits (SCR_W=160, SCR_H=120).
- One sub-module, `self_pixel_scan`:
  - Column/row counters with `start` input.
  - `fire` select.
  - Outputs `col`, `row`, `in_fire`, `last`.
  - Reused by DRAW and ERASE.
- FSM, HOLD counter and output registers live in `self_draw`.

## Test plan
- Reset release, controller gives `op`=00, `x`=82, `self_enable`=1 → 32 `plot` pulses.
  - (82..89, 110..113) row-major, `colour`=111.
  - Then `self_state`=3 for 20 cycles.
- `op`=10, `x`=40 at LOAD_D → 16 pixels.
  - (44, 94..109), `colour`=100.
  - Then 32 ship pixels, then HOLD.
- Draw at `x`=82, controller moves `x` to 92 during HOLD, erase `op`=01 → erase writes `colour`=000 at columns 82..89, not 92..99; `frame_done` pulses once on the last erase pixel.
- `x`=156 draw → columns 156..159 plotted; columns 160..163 have `plot`=0; DRAW still 32 cycles.
- Hold `self_enable`=0 in LOAD_E for 50 cycles, and present `op`=00 in LOAD_E → no `plot`, `self_state` stays 2 until `op`=01 & `self_enable`=1.
- Assert `reset_n`=0 at pixel 10 of DRAW → `plot`=0 immediately, `self_state`=1; the next frame restarts from pixel 0 with new `x`.
